// File: rtl/hwpe_stream_engine.sv
// hwpe_stream_engine: joins NB_OPERANDS operand streams, applies a per-job
// element-wise integer op (ADD/SUB/MIN/MAX), and emits results through an
// elastic PIPE_DEPTH-stage pipeline. It counts delivered results against the
// programmed job length and pulses a per-core completion event.
// Optional build macro: HWPE_STREAM_ENGINE_SAT_EN saturates ADD/SUB to the
// signed DATA_WIDTH range instead of wrapping.
module hwpe_stream_engine #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NB_OPERANDS = 2,
  parameter int unsigned N_CORES     = 2,
  parameter int unsigned PIPE_DEPTH  = 2,
  parameter int unsigned LEN_WIDTH   = 16,
  localparam int unsigned CID_W      = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              start_i,
  input  logic [LEN_WIDTH-1:0]              len_i,
  input  logic [1:0]                        opcode_i,
  input  logic [CID_W-1:0]                  core_id_i,
  input  logic [NB_OPERANDS-1:0]            op_valid_i,
  output logic [NB_OPERANDS-1:0]            op_ready_o,
  input  logic [NB_OPERANDS*DATA_WIDTH-1:0] op_data_i,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [DATA_WIDTH-1:0]             res_data_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [N_CORES-1:0]                evt_o,
  output logic [LEN_WIDTH-1:0]              count_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MIN, OP_MAX} op_e;

  state_e                 state_q;
  op_e                    opcode_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [CID_W-1:0]       core_id_q;
  logic [LEN_WIDTH-1:0]   in_cnt_q;
  logic [LEN_WIDTH-1:0]   out_cnt_q;
  logic [LEN_WIDTH-1:0]   out_cnt_d;
  logic                   busy_q;
  logic                   done_q;
  logic [N_CORES-1:0]     evt_q;

  logic                   fire;
  logic                   res_hs;
  logic [PIPE_DEPTH-1:0]  vld_q;
  logic [DATA_WIDTH-1:0]  dat_q [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0]  stg_rdy;

  logic signed [DATA_WIDTH-1:0] ops [NB_OPERANDS];
  logic signed [DATA_WIDTH-1:0] sum_c;
  logic signed [DATA_WIDTH-1:0] mn_c;
  logic signed [DATA_WIDTH-1:0] mx_c;
  logic        [DATA_WIDTH-1:0] res_c;

  // Unpack the operand bus, operand 0 in the LSBs
  always_comb begin
    for (int unsigned i = 0; i < NB_OPERANDS; i++) begin
      ops[i] = op_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef HWPE_STREAM_ENGINE_SAT_EN
  localparam int unsigned EW = DATA_WIDTH + $clog2(NB_OPERANDS) + 1;
  localparam logic signed [EW-1:0] SMAX = {{(EW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  logic signed [EW-1:0] acc;
  logic signed [EW-1:0] ext;

  // Wide ADD/SUB accumulation, clamped back to the signed DATA_WIDTH range
  always_comb begin
    acc = {{(EW-DATA_WIDTH){ops[0][DATA_WIDTH-1]}}, ops[0]};
    ext = '0;
    for (int unsigned i = 1; i < NB_OPERANDS; i++) begin
      ext = {{(EW-DATA_WIDTH){ops[i][DATA_WIDTH-1]}}, ops[i]};
      if (opcode_q == OP_SUB) acc = acc - ext;
      else                    acc = acc + ext;
    end
    if (acc > SMAX)      sum_c = SMAX[DATA_WIDTH-1:0];
    else if (acc < SMIN) sum_c = SMIN[DATA_WIDTH-1:0];
    else                 sum_c = acc[DATA_WIDTH-1:0];
  end
`else
  // Wrapping ADD/SUB at DATA_WIDTH
  always_comb begin
    sum_c = ops[0];
    for (int unsigned i = 1; i < NB_OPERANDS; i++) begin
      if (opcode_q == OP_SUB) sum_c = sum_c - ops[i];
      else                    sum_c = sum_c + ops[i];
    end
  end
`endif

  // Signed min/max reduction and op select feeding stage 0
  always_comb begin
    mn_c = ops[0];
    mx_c = ops[0];
    for (int unsigned i = 1; i < NB_OPERANDS; i++) begin
      if (ops[i] < mn_c) mn_c = ops[i];
      if (ops[i] > mx_c) mx_c = ops[i];
    end
    case (opcode_q)
      OP_MIN:  res_c = mn_c;
      OP_MAX:  res_c = mx_c;
      default: res_c = sum_c;
    endcase
  end

  // Stage k can load if any stage from k to the output is empty or the sink
  // accepts; computed directly from the valid bits to avoid a ready chain.
  always_comb begin
    logic r;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      r = res_ready_i;
      for (int unsigned j = k; j < PIPE_DEPTH; j++) begin
        if (!vld_q[j]) r = 1'b1;
      end
      stg_rdy[k] = r;
    end
  end

  assign fire        = (state_q == S_RUN) && (&op_valid_i) && stg_rdy[0] && (in_cnt_q < len_q);
  assign op_ready_o  = {NB_OPERANDS{fire}};
  assign res_valid_o = vld_q[PIPE_DEPTH-1];
  assign res_data_o  = dat_q[PIPE_DEPTH-1];
  assign res_hs      = res_valid_o && res_ready_i;
  assign out_cnt_d   = out_cnt_q + LEN_WIDTH'(res_hs);

  // Elastic result pipeline; a full stage holds while downstream stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) dat_q[k] <= '0;
    end else if (clear_i) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) dat_q[k] <= '0;
    end else begin
      if (stg_rdy[0]) begin
        vld_q[0] <= fire;
        if (fire) dat_q[0] <= res_c;
      end
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        if (stg_rdy[k]) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  // Job control FSM with registered busy/done/event outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      opcode_q  <= OP_ADD;
      len_q     <= '0;
      core_id_q <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      evt_q     <= '0;
    end else if (clear_i) begin
      state_q   <= S_IDLE;
      opcode_q  <= OP_ADD;
      len_q     <= '0;
      core_id_q <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      evt_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      evt_q     <= '0;
      out_cnt_q <= out_cnt_d;
      if (fire) in_cnt_q <= in_cnt_q + LEN_WIDTH'(1);
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_q     <= len_i;
            opcode_q  <= op_e'(opcode_i);
            core_id_q <= core_id_i;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            if (len_i == '0) begin
              state_q <= S_FIN;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (fire && ((in_cnt_q + LEN_WIDTH'(1)) == len_q)) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // Uses the post-handshake count so a final transfer this cycle
          // moves straight to FIN.
          if (out_cnt_d == len_q) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
          end
        end
        S_FIN: begin
          done_q           <= 1'b1;
          evt_q[core_id_q] <= 1'b1;
          state_q          <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign evt_o   = evt_q;
  assign count_o = out_cnt_q;

endmodule

// File: tb/tb_hwpe_stream_engine.sv
// Directed self-checking bench for hwpe_stream_engine: a 2-operand instance
// for streaming/handshake/clear tests and a 3-operand instance for MIN/MAX.
module tb_hwpe_stream_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;

  // 2-operand DUT signals
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic [1:0]  opc = '0;
  logic        core = 1'b0;
  logic [1:0]  ov = '0;
  logic [1:0]  ordy;
  logic [63:0] od = '0;
  logic        rv;
  logic        rr = 1'b1;
  logic [31:0] rd;
  logic        busy;
  logic        done;
  logic [1:0]  evt;
  logic [15:0] cnt;

  // 3-operand DUT signals
  logic        clear3 = 1'b0;
  logic        start3 = 1'b0;
  logic [15:0] len3 = '0;
  logic [1:0]  opc3 = '0;
  logic        core3 = 1'b0;
  logic [2:0]  ov3 = '0;
  logic [2:0]  ordy3;
  logic [95:0] od3 = '0;
  logic        rv3;
  logic        rr3 = 1'b1;
  logic [31:0] rd3;
  logic        busy3;
  logic        done3;
  logic [1:0]  evt3;
  logic [15:0] cnt3;

  // Per-job vectors and expected results
  logic [31:0] va [4];
  logic [31:0] vb [4];
  logic [31:0] vc [4];
  logic [31:0] ve [4];
  logic [31:0] exp2 [4] = '{32'd3, 32'd7, 32'd11, 32'd15};

  always #5 clk = ~clk;

  hwpe_stream_engine #(.DATA_WIDTH(32), .NB_OPERANDS(2), .N_CORES(2), .PIPE_DEPTH(2), .LEN_WIDTH(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .len_i(len),
    .opcode_i(opc), .core_id_i(core), .op_valid_i(ov), .op_ready_o(ordy), .op_data_i(od),
    .res_valid_o(rv), .res_ready_i(rr), .res_data_o(rd), .busy_o(busy), .done_o(done),
    .evt_o(evt), .count_o(cnt)
  );

  hwpe_stream_engine #(.DATA_WIDTH(32), .NB_OPERANDS(3), .N_CORES(2), .PIPE_DEPTH(2), .LEN_WIDTH(16)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear3), .start_i(start3), .len_i(len3),
    .opcode_i(opc3), .core_id_i(core3), .op_valid_i(ov3), .op_ready_o(ordy3), .op_data_i(od3),
    .res_valid_o(rv3), .res_ready_i(rr3), .res_data_o(rd3), .busy_o(busy3), .done_o(done3),
    .evt_o(evt3), .count_o(cnt3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one job on the 2-operand DUT using va/vb/ve, with optional op1 skew
  // and alternating result backpressure.
  task automatic run2(input logic [1:0] o, input logic c_id, input int n, input bit toggle, input int skew);
    int k = 0;
    int m = 0;
    int c = 0;
    bit held = 1'b0;
    bit seen = 1'b0;
    logic [31:0] hd = '0;
    start = 1'b1; len = 16'(n); opc = o; core = c_id;
    step();
    start = 1'b0;
    while ((m < n || !seen) && c < 200) begin
      rr = toggle ? (c % 2 == 0) : 1'b1;
      if (k < n) begin
        ov = (c < skew) ? 2'b01 : 2'b11;
        od = {vb[k], va[k]};
      end else begin
        ov = 2'b00;
      end
      @(negedge clk);
      if (c < skew) chk("skew_no_ready", ordy, 2'b00);
      chk("join_all_or_none", (ordy == 2'b00 || ordy == 2'b11), 1);
      if (ordy == 2'b11) k++;
      if (held) begin
        chk("stall_valid", rv, 1);
        chk("stall_data", rd, hd);
      end
      if (rv && rr) begin
        chk("result", rd, ve[m]);
        m++;
        held = 1'b0;
      end else if (rv) begin
        held = 1'b1;
        hd = rd;
      end else begin
        held = 1'b0;
      end
      if (evt !== 2'b00) begin
        chk("evt_onehot", evt, c_id ? 2'b10 : 2'b01);
        chk("done_with_evt", done, 1);
        chk("all_results_before_done", m, n);
        seen = 1'b1;
      end
      step();
      c++;
    end
    ov = 2'b00;
    rr = 1'b1;
    chk("job_complete", {seen, (m == n)}, 2'b11);
    chk("count_final", cnt, 16'(n));
    chk("done_drop", done, 0);
    chk("evt_drop", evt, 0);
  endtask

  // Run one job on the 3-operand DUT using va/vb/vc/ve
  task automatic run3(input logic [1:0] o, input int n);
    int k = 0;
    int m = 0;
    int c = 0;
    bit seen = 1'b0;
    start3 = 1'b1; len3 = 16'(n); opc3 = o; core3 = 1'b0;
    step();
    start3 = 1'b0;
    while ((m < n || !seen) && c < 200) begin
      if (k < n) begin
        ov3 = 3'b111;
        od3 = {vc[k], vb[k], va[k]};
      end else begin
        ov3 = 3'b000;
      end
      @(negedge clk);
      if (ordy3 == 3'b111) k++;
      if (rv3) begin
        chk("result3", rd3, ve[m]);
        m++;
      end
      if (evt3 !== 2'b00) begin
        chk("evt3", evt3, 2'b01);
        seen = 1'b1;
      end
      step();
      c++;
    end
    ov3 = 3'b000;
    chk("job3_complete", {seen, (m == n)}, 2'b11);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_evt", evt, 0);
    chk("rst_res_valid", rv, 0);
    chk("rst_count", cnt, 0);
    chk("rst_res_data", rd, 0);
    rst_n = 1'b1;
    step();

    // Test 1: len 0 job targeting core 1
    ov = 2'b11; od = {32'd1, 32'd1};
    start = 1'b1; len = 16'd0; opc = 2'b00; core = 1'b1;
    @(negedge clk);
    chk("len0_idle_ready", ordy, 2'b00);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("len0_fin_ready", ordy, 2'b00);
    chk("len0_done_c1", done, 0);
    chk("len0_busy_c1", busy, 0);
    step();
    chk("len0_done_c2", done, 1);
    chk("len0_evt_c2", evt, 2'b10);
    chk("len0_busy_c2", busy, 0);
    step();
    chk("len0_done_c3", done, 0);
    chk("len0_evt_c3", evt, 2'b00);
    ov = 2'b00;

    // Test 2: ADD streaming, len 4, no backpressure, exact latency
    rr = 1'b1;
    start = 1'b1; len = 16'd4; opc = 2'b00; core = 1'b0;
    step();
    start = 1'b0;
    chk("add_busy_run", busy, 1);
    for (int i = 0; i < 4; i++) begin
      ov = 2'b11;
      od = {32'(2*i+2), 32'(2*i+1)};
      if (i >= 2) begin
        chk("add_valid", rv, 1);
        chk("add_data", rd, exp2[i-2]);
      end else begin
        chk("add_latency", rv, 0);
      end
      @(negedge clk);
      chk("add_fire", ordy, 2'b11);
      step();
    end
    @(negedge clk);
    chk("add_drain_no_accept", ordy, 2'b00);
    ov = 2'b00;
    chk("add_valid3", rv, 1);
    chk("add_data3", rd, exp2[2]);
    chk("add_count2", cnt, 2);
    chk("add_busy_drain", busy, 1);
    step();
    chk("add_data4", rd, exp2[3]);
    chk("add_count3", cnt, 3);
    step();
    chk("add_empty", rv, 0);
    chk("add_count4", cnt, 4);
    chk("add_busy_fin", busy, 0);
    step();
    chk("add_done", done, 1);
    chk("add_evt", evt, 2'b01);
    chk("add_count_hold", cnt, 4);
    step();
    chk("add_done_drop", done, 0);
    chk("add_evt_drop", evt, 2'b00);

    // Test 3: SUB with op1 skew of 3 cycles and toggling result ready
    va[0] = 32'd10;  vb[0] = 32'd3; ve[0] = 32'd7;
    va[1] = 32'd20;  vb[1] = 32'd5; ve[1] = 32'd15;
    va[2] = 32'd100; vb[2] = 32'd1; ve[2] = 32'd99;
    run2(2'b01, 1'b1, 3, 1'b1, 3);

    // Test 4: signed MIN/MAX on three operands
    va[0] = 32'hFFFF_FFFB; vb[0] = 32'd7;          vc[0] = 32'd0;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFF8; vc[1] = 32'hFFFF_FFFD;
    ve[0] = 32'hFFFF_FFFB; ve[1] = 32'hFFFF_FFF8;
    run3(2'b10, 2);
    ve[0] = 32'd7;         ve[1] = 32'hFFFF_FFFF;
    run3(2'b11, 2);

    // Test 5: ADD overflow in both directions
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'd1;
    va[1] = 32'h8000_0000; vb[1] = 32'hFFFF_FFFF;
`ifdef HWPE_STREAM_ENGINE_SAT_EN
    ve[0] = 32'h7FFF_FFFF; ve[1] = 32'h8000_0000;
`else
    ve[0] = 32'h8000_0000; ve[1] = 32'h7FFF_FFFF;
`endif
    run2(2'b00, 1'b0, 2, 1'b0, 0);

    // Test 6: clear mid-DRAIN with two results in flight
    rr = 1'b0;
    start = 1'b1; len = 16'd2; opc = 2'b00; core = 1'b0;
    step();
    start = 1'b0;
    ov = 2'b11; od = {32'd2, 32'd1};
    @(negedge clk);
    chk("clr_fire1", ordy, 2'b11);
    step();
    od = {32'd4, 32'd3};
    @(negedge clk);
    chk("clr_fire2", ordy, 2'b11);
    step();
    ov = 2'b00;
    chk("clr_pre_busy", busy, 1);
    chk("clr_pre_valid", rv, 1);
    chk("clr_pre_data", rd, 32'd3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_valid", rv, 0);
    chk("clr_busy", busy, 0);
    chk("clr_count", cnt, 0);
    chk("clr_evt", evt, 0);
    chk("clr_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clr_no_evt", evt, 0);
      chk("clr_no_valid", rv, 0);
    end
    rr = 1'b1;
    va[0] = 32'd5; vb[0] = 32'd6; ve[0] = 32'd11;
    va[1] = 32'd7; vb[1] = 32'd8; ve[1] = 32'd15;
    run2(2'b00, 1'b1, 2, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
